// File: rtl/divider_unit.sv
// ---------------------------------------------------------------------------
// divider_unit
//
// Multi-cycle RV32M divide / remainder unit (DIV, DIVU, REM, REMU) for the
// execute stage. The core drives the operands together with a one-cycle start
// pulse, then waits until busy drops and takes result.
//
// The core uses restoring division on operand magnitudes and produces one
// quotient bit per cycle, MSB first. A one-cycle fixup stage then restores
// the signs. Divide-by-zero and the signed overflow case (most negative value
// divided by -1) bypass the iteration and complete after a single busy cycle.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, an operation whose dividend magnitude is smaller than its
//   divisor magnitude also completes after a single busy cycle (q = 0,
//   r = dividend). Results are identical with or without the macro.
//
// Ports
//   clk       in   1     system clock, all state changes on posedge
//   reset     in   1     synchronous active-high reset
//   start     in   1     one-cycle request pulse, accepted only when idle
//   op        in   2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data  in   XLEN  dividend
//   rs2_data  in   XLEN  divisor
//   result    out  XLEN  quotient or remainder of the last completed operation
//   busy      out  1     high while an accepted operation is in flight
// ---------------------------------------------------------------------------
module divider_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIXUP,
        DONE1
    } state_t;

    state_t state;
    state_t next_state;

    // Operation context captured when a request is accepted.
    logic            is_rem_q;
    logic            q_neg;
    logic            r_neg;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dsr;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] fast_value;

    // Request decode, evaluated on the accept cycle.
    logic            is_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic            overflow;
    logic            early_out;
    logic            take_fast;
    logic [XLEN-1:0] fast_result;

    // Iteration datapath.
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    logic [XLEN-1:0] q_final;
    logic [XLEN-1:0] r_final;

    // Decode the incoming request. For signed operations the magnitudes come
    // from two's complement negation; the most negative value negates to
    // itself, which is exactly its magnitude when read as unsigned.
    always_comb begin
        is_signed = ~op[0];
        rs1_neg   = is_signed & rs1_data[XLEN-1];
        rs2_neg   = is_signed & rs2_data[XLEN-1];
        rs1_mag   = rs1_neg ? (XLEN'(0) - rs1_data) : rs1_data;
        rs2_mag   = rs2_neg ? (XLEN'(0) - rs2_data) : rs2_data;
        div_zero  = (rs2_data == '0);
        overflow  = is_signed && (rs1_data == MOST_NEG) && (rs2_data == '1);
`ifdef DIV_EARLY_OUT_EN
        early_out = !div_zero && !overflow && (rs1_mag < rs2_mag);
`else
        early_out = 1'b0;
`endif
        take_fast = div_zero | overflow | early_out;

        // Divide by zero: quotient is all ones, remainder is the dividend.
        // Overflow: quotient is the dividend, remainder is zero.
        // Early out: quotient is zero, remainder is the dividend.
        fast_result = '0;
        if (div_zero) begin
            fast_result = op[1] ? rs1_data : '1;
        end else if (overflow) begin
            fast_result = op[1] ? '0 : MOST_NEG;
        end else begin
            fast_result = op[1] ? rs1_data : '0;
        end
    end

    // One restoring step: bring in the next dividend bit and keep the
    // subtraction only when it does not go negative. The trial is one bit
    // wider than the operands so no borrow information is lost.
    always_comb begin
        rem_shift = {rem, dvd[XLEN-1]};
        trial     = rem_shift - {1'b0, dsr};
        trial_ok  = ~trial[XLEN];
        q_final   = q_neg ? (XLEN'(0) - dvd) : dvd;
        r_final   = r_neg ? (XLEN'(0) - rem) : rem;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and busy flag. Start is only looked at while idle, so
    // a pulse during an operation has no effect.
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = take_fast ? DONE1 : DIVIDE;
                end
            end
            DIVIDE: begin
                if (count == LAST_ITER) begin
                    next_state = FIXUP;
                end
            end
            FIXUP: begin
                next_state = IDLE;
            end
            DONE1: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. The dividend register doubles as the quotient: each
    // step shifts it left and drops the new quotient bit into the LSB, so
    // after XLEN steps it holds the full quotient. result only changes on
    // the cycle an operation completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_rem_q   <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            dvd        <= '0;
            dsr        <= '0;
            rem        <= '0;
            count      <= '0;
            fast_value <= '0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_rem_q   <= op[1];
                        q_neg      <= rs1_neg ^ rs2_neg;
                        r_neg      <= rs1_neg;
                        dvd        <= rs1_mag;
                        dsr        <= rs2_mag;
                        rem        <= '0;
                        count      <= '0;
                        fast_value <= fast_result;
                    end
                end
                DIVIDE: begin
                    rem   <= trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
                    dvd   <= {dvd[XLEN-2:0], trial_ok};
                    count <= count + 1'b1;
                end
                FIXUP: begin
                    result <= is_rem_q ? r_final : q_final;
                end
                DONE1: begin
                    result <= fast_value;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// ---------------------------------------------------------------------------
// tb_divider_unit
//
// Directed testbench for divider_unit with hand-computed expected values.
// Each vector is started the same cycle the previous operation frees the
// unit, so back-to-back acceptance is exercised throughout.
// ---------------------------------------------------------------------------
module tb_divider_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int FULL_CYCLES = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_CYCLES = 1;
`else
    localparam int EARLY_CYCLES = 33;
`endif
    localparam int BUSY_LIMIT = 100;

    typedef struct {
        string       tag;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        int          cycles;
    } vector_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] result;
    logic        busy;

    int assertions;
    int failures;
    int busyCycles;
    logic [31:0] lastExpected;
    vector_t vectors[$];

    divider_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs1_data (rs1Data),
        .rs2_data (rs2Data),
        .result   (result),
        .busy     (busy)
    );

    // 10 ns clock; stimulus and sampling happen on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Pulse start from the current falling edge, then count how many cycles
    // busy stays high. Returns at the first falling edge with busy low.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a,
                                 input logic [31:0] b, output int cycles);
        op      = opIn;
        rs1Data = a;
        rs2Data = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        rs1Data = 32'hDEAD_BEEF;
        rs2Data = 32'h1234_5678;
        cycles  = 0;
        while (busy && cycles < BUSY_LIMIT) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        op         = OP_DIVU;
        rs1Data    = '0;
        rs2Data    = '0;

        vectors.push_back('{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         FULL_CYCLES});
        vectors.push_back('{"remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          FULL_CYCLES});
        vectors.push_back('{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  FULL_CYCLES});
        vectors.push_back('{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  FULL_CYCLES});
        vectors.push_back('{"div_7_m2",     OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  FULL_CYCLES});
        vectors.push_back('{"rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          FULL_CYCLES});
        vectors.push_back('{"div_m100_7",   OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  FULL_CYCLES});
        vectors.push_back('{"rem_m100_7",   OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  FULL_CYCLES});
        vectors.push_back('{"divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  FULL_CYCLES});
        vectors.push_back('{"remu_max_16",  OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F,  FULL_CYCLES});
        vectors.push_back('{"div_min_2",    OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  FULL_CYCLES});
        vectors.push_back('{"divu_5_0",     OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vectors.push_back('{"rem_5_0",      OP_REM,  32'd5,          32'd0,          32'd5,          1});
        vectors.push_back('{"div_m5_0",     OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1});
        vectors.push_back('{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vectors.push_back('{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vectors.push_back('{"divu_3_10",    OP_DIVU, 32'd3,          32'd10,         32'd0,          EARLY_CYCLES});
        vectors.push_back('{"remu_3_10",    OP_REMU, 32'd3,          32'd10,         32'd3,          EARLY_CYCLES});
        vectors.push_back('{"div_m3_10",    OP_DIV,  32'hFFFF_FFFD,  32'd10,         32'd0,          EARLY_CYCLES});
        vectors.push_back('{"rem_m3_10",    OP_REM,  32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  EARLY_CYCLES});

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, each started as soon as the previous one frees
        // the unit.
        foreach (vectors[i]) begin
            applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b, busyCycles);
            checkOutput({vectors[i].tag, "_result"}, result, vectors[i].expected);
            checkOutput({vectors[i].tag, "_cycles"}, busyCycles, vectors[i].cycles);
            lastExpected = vectors[i].expected;
        end

        // A start pulse in cycle 5 of an operation in flight must be ignored,
        // and result must keep the previous value while busy.
        op      = OP_DIVU;
        rs1Data = 32'd1000;
        rs2Data = 32'd10;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("inflight_busy", {31'd0, busy}, 32'd1);
        checkOutput("inflight_hold", result, lastExpected);
        op      = OP_DIVU;
        rs1Data = 32'd7;
        rs2Data = 32'd7;
        start   = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        busyCycles = 5;
        while (busy && busyCycles < BUSY_LIMIT) begin
            busyCycles++;
            @(negedge clk);
        end
        checkOutput("ignored_start_result", result, 32'd100);
        checkOutput("ignored_start_cycles", busyCycles, FULL_CYCLES);

        // Reset at cycle 10 aborts the operation.
        op      = OP_DIVU;
        rs1Data = 32'd50;
        rs2Data = 32'd5;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(OP_DIVU, 32'd9, 32'd3, busyCycles);
        checkOutput("post_reset_result", result, 32'd3);
        checkOutput("post_reset_cycles", busyCycles, FULL_CYCLES);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
